// File: rtl/src_ram_pkg.sv
// Shared constants and FSM encoding for the source feature-map RAM read path.
package src_ram_pkg;

   localparam int unsigned SRC_LANES  = 9;
   localparam int unsigned SRC_ADDR_W = 12;
   localparam int unsigned SRC_DATA_W = 8;
   localparam int unsigned SRC_IDX_W  = $clog2(SRC_LANES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } src_state_e;

endpackage : src_ram_pkg

// File: rtl/ram_lat_pipe.sv
// DEPTH-stage shift register of {valid, index}; tracks reads through a fixed-latency RAM.
module ram_lat_pipe #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned IDX_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_valid,
   input  logic [IDX_W-1:0] i_idx,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);

   logic [DEPTH-1:0]            vld_q, vld_d;
   logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

   // Shift one stage per cycle, new entry enters stage 0.
   always_comb begin
      vld_d    = '0;
      idx_d    = '0;
      vld_d[0] = i_valid;
      idx_d[0] = i_idx;
      for (int s = 1; s < int'(DEPTH); s++) begin
         vld_d[s] = vld_q[s-1];
         idx_d[s] = idx_q[s-1];
      end
   end

   // Stage registers; reset empties the line so in-flight reads are forgotten.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

   assign o_valid = vld_q[DEPTH-1];
   assign o_idx   = idx_q[DEPTH-1];

endmodule : ram_lat_pipe

// File: rtl/src_ram_read_seq.sv
// Serialises a 9-lane address bundle onto one RAM read port and returns the bytes as one word.
module src_ram_read_seq
   import src_ram_pkg::*;
#(
   parameter int unsigned LANES   = SRC_LANES,
   parameter int unsigned ADDR_W  = SRC_ADDR_W,
   parameter int unsigned DATA_W  = SRC_DATA_W,
   parameter int unsigned RAM_LAT = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [LANES*ADDR_W-1:0] i_addr,
   input  logic                    i_startRead,
   output logic [ADDR_W-1:0]       o_ramAddr,
   output logic                    o_ramRe,
   input  logic [DATA_W-1:0]       i_ramData,
   output logic [LANES*DATA_W-1:0] o_data,
   output logic                    o_dataValid,
   output logic                    o_busy,
   output logic                    o_dropped
);

   localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   src_state_e state_q, state_d;
   logic [IDX_W-1:0]                cnt_q, cnt_d;
   logic [LANES-1:0][ADDR_W-1:0]    addr_q, addr_d;
   logic [LANES-1:0][DATA_W-1:0]    cap_q, cap_d;
   logic                            last_q, last_d;
   logic [ADDR_W-1:0]               ram_addr_q, ram_addr_d;
   logic                            ram_re_q, ram_re_d;
   logic [LANES-1:0][DATA_W-1:0]    data_q, data_d;
   logic                            valid_q, valid_d;
   logic                            busy_q, busy_d;
   logic                            dropped_q, dropped_d;

   logic                            pipe_vld;
   logic [IDX_W-1:0]                pipe_idx;
   logic [IDX_W-1:0]                cnt_nxt;
   logic [LANES-1:0][ADDR_W-1:0]    addr_in;

   assign addr_in = i_addr;
   assign cnt_nxt = cnt_q + IDX_W'(1);

   // Tag each issued read with its lane so the return can be steered to the right slot.
   ram_lat_pipe #(
      .DEPTH (RAM_LAT),
      .IDX_W (IDX_W)
   ) u_lat_pipe (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_valid (ram_re_q),
      .i_idx   (cnt_q),
      .o_valid (pipe_vld),
      .o_idx   (pipe_idx)
   );

   // Next-state, capture and registered-output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      cap_d      = cap_q;
      last_d     = last_q;
      ram_addr_d = ram_addr_q;
      ram_re_d   = 1'b0;
      data_d     = data_q;
      valid_d    = 1'b0;
      busy_d     = 1'b0;
      dropped_d  = 1'b0;

      if (pipe_vld && (32'(pipe_idx) < LANES)) begin
         cap_d[pipe_idx] = i_ramData;
         if (pipe_idx == LAST_IDX) begin
            last_d = 1'b1;
         end
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (i_startRead) begin
               state_d    = ST_ISSUE;
               addr_d     = addr_in;
               cnt_d      = '0;
               last_d     = 1'b0;
               ram_re_d   = 1'b1;
               ram_addr_d = addr_in[0];
               busy_d     = 1'b1;
            end
         end
         ST_ISSUE: begin
            busy_d    = 1'b1;
            dropped_d = i_startRead;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_DRAIN;
            end else begin
               cnt_d      = cnt_nxt;
               ram_re_d   = 1'b1;
               ram_addr_d = addr_q[cnt_nxt];
            end
         end
         ST_DRAIN: begin
            dropped_d = i_startRead;
            if (last_q) begin
               state_d = ST_DONE;
               data_d  = cap_q;
               valid_d = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         cap_q      <= '0;
         last_q     <= 1'b0;
         ram_addr_q <= '0;
         ram_re_q   <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         cap_q      <= cap_d;
         last_q     <= last_d;
         ram_addr_q <= ram_addr_d;
         ram_re_q   <= ram_re_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
      end
   end

   assign o_ramAddr   = ram_addr_q;
   assign o_ramRe     = ram_re_q;
   assign o_data      = data_q;
   assign o_dataValid = valid_q;
   assign o_busy      = busy_q;
   assign o_dropped   = dropped_q;

endmodule : src_ram_read_seq

// File: tb/tb_src_ram_read_seq.sv
// Directed bench for src_ram_read_seq at RAM_LAT=1 and RAM_LAT=3.
module tb_src_ram_read_seq;

   logic         clk;
   logic         rst_n;

   logic [107:0] addr1, addr3;
   logic         start1, start3;
   logic [11:0]  ram_addr1, ram_addr3;
   logic         ram_re1, ram_re3;
   logic [7:0]   ram_data1, ram_data3;
   logic [71:0]  data1, data3;
   logic         valid1, valid3;
   logic         busy1, busy3;
   logic         dropped1, dropped3;

   int tests;
   int errors;

   src_ram_read_seq #(.RAM_LAT(1)) u_dut1 (
      .i_clk       (clk),
      .i_rstn      (rst_n),
      .i_addr      (addr1),
      .i_startRead (start1),
      .o_ramAddr   (ram_addr1),
      .o_ramRe     (ram_re1),
      .i_ramData   (ram_data1),
      .o_data      (data1),
      .o_dataValid (valid1),
      .o_busy      (busy1),
      .o_dropped   (dropped1)
   );

   src_ram_read_seq #(.RAM_LAT(3)) u_dut3 (
      .i_clk       (clk),
      .i_rstn      (rst_n),
      .i_addr      (addr3),
      .i_startRead (start3),
      .o_ramAddr   (ram_addr3),
      .o_ramRe     (ram_re3),
      .i_ramData   (ram_data3),
      .o_data      (data3),
      .o_dataValid (valid3),
      .o_busy      (busy3),
      .o_dropped   (dropped3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM contents: mem[a] = a[7:0], except the top word holds 0xA5.
   function automatic logic [7:0] mem_fn(input logic [11:0] a);
      return (a == 12'hFFF) ? 8'hA5 : a[7:0];
   endfunction

   // Latency-1 RAM model; it is never reset, so aborted reads still return data.
   logic [7:0] r1_q;
   always @(posedge clk) begin
      if (ram_re1) r1_q <= mem_fn(ram_addr1);
   end
   assign ram_data1 = r1_q;

   // Latency-3 RAM model.
   logic [7:0] r3_q [3];
   always @(posedge clk) begin
      if (ram_re3) r3_q[0] <= mem_fn(ram_addr3);
      r3_q[1] <= r3_q[0];
      r3_q[2] <= r3_q[1];
   end
   assign ram_data3 = r3_q[2];

   function automatic logic [107:0] seq_addr(input logic [11:0] base);
      logic [107:0] r;
      r = '0;
      for (int j = 0; j < 9; j++) r[j*12 +: 12] = base + 12'(j);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int n;
   int busy_cnt;
   int drop_cnt;
   int valid_cnt;
   logic stable;
   logic [71:0] held;

   initial begin
      tests = 0;
      errors = 0;
      rst_n = 1'b0;
      addr1 = '0;
      addr3 = '0;
      start1 = 1'b0;
      start3 = 1'b0;

      // Reset values
      #12;
      chk("rst_ram_re", 128'(ram_re1), 128'(0));
      chk("rst_ram_addr", 128'(ram_addr1), 128'(0));
      chk("rst_data", 128'(data1), 128'(0));
      chk("rst_valid_busy_drop", 128'({valid1, busy1, dropped1}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single request, addresses 0x010..0x018
      addr1 = seq_addr(12'h010);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("t1_busy_at_accept", 128'(busy1), 128'(1));
      for (int j = 0; j < 9; j++) begin
         if (j > 0) tick();
         chk($sformatf("t1_ram_re_lane%0d", j), 128'(ram_re1), 128'(1));
         chk($sformatf("t1_ram_addr_lane%0d", j), 128'(ram_addr1), 128'(12'h010 + 12'(j)));
      end
      n = 9;
      while (!valid1 && n < 40) begin
         tick();
         n++;
         if (n == 10) chk("t1_ram_re_drain", 128'(ram_re1), 128'(0));
      end
      chk("t1_latency", 128'(n), 128'(12));
      chk("t1_data", 128'(data1), 128'(72'h181716151413121110));
      chk("t1_busy_done", 128'(busy1), 128'(0));
      tick();
      chk("t1_valid_one_cycle", 128'(valid1), 128'(0));
      chk("t1_data_held", 128'(data1), 128'(72'h181716151413121110));

      // RAM_LAT=3, all addresses 0xFFF
      addr3 = {9{12'hFFF}};
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      n = 1;
      busy_cnt = busy3 ? 1 : 0;
      while (!valid3 && n < 40) begin
         tick();
         n++;
         if (busy3) busy_cnt++;
      end
      chk("t2_latency", 128'(n), 128'(14));
      chk("t2_data", 128'(data3), 128'({9{8'hA5}}));
      chk("t2_busy_cycles", 128'(busy_cnt), 128'(13));

      // Start held for 3 cycles: one accept, two drops
      tick();
      addr1 = seq_addr(12'h060);
      start1 = 1'b1;
      drop_cnt = 0;
      valid_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (c == 2) start1 = 1'b0;
         if (dropped1) drop_cnt++;
         if (valid1) valid_cnt++;
         if (c == 1) chk("t3_dropped_after_e1", 128'(dropped1), 128'(1));
      end
      chk("t3_drop_count", 128'(drop_cnt), 128'(2));
      chk("t3_valid_count", 128'(valid_cnt), 128'(1));
      chk("t3_data", 128'(data1), 128'(72'h686766656463626160));

      // Back-to-back: second start sampled in the DONE cycle
      addr1 = seq_addr(12'h020);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1;
      while (!valid1 && n < 40) begin
         tick();
         n++;
      end
      chk("t4_first_latency", 128'(n), 128'(12));
      chk("t4_first_data", 128'(data1), 128'(72'h282726252423222120));
      held = data1;
      addr1 = seq_addr(12'h100);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1;
      stable = 1'b1;
      while (!valid1 && n < 40) begin
         if (data1 !== held) stable = 1'b0;
         addr1 = {$urandom, $urandom, $urandom, $urandom};
         tick();
         n++;
      end
      chk("t4_spacing", 128'(n), 128'(12));
      chk("t4_first_held", 128'(stable), 128'(1));
      chk("t4_second_data", 128'(data1), 128'(72'h080706050403020100));
      tick();

      // i_addr scrambled every cycle after accept
      addr1 = seq_addr(12'h030);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1;
      while (!valid1 && n < 40) begin
         addr1 = {$urandom, $urandom, $urandom, $urandom};
         tick();
         n++;
      end
      chk("t6_latency", 128'(n), 128'(12));
      chk("t6_data", 128'(data1), 128'(72'h383736353433323130));
      tick();

      // Reset on the 5th ISSUE cycle
      addr1 = seq_addr(12'h040);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      chk("t5_addr_before_rst", 128'(ram_addr1), 128'(12'h044));
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ram_re", 128'(ram_re1), 128'(0));
      chk("t5_rst_ram_addr", 128'(ram_addr1), 128'(0));
      chk("t5_rst_data", 128'(data1), 128'(0));
      chk("t5_rst_valid_busy_drop", 128'({valid1, busy1, dropped1}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      valid_cnt = 0;
      busy_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (valid1) valid_cnt++;
         if (busy1) busy_cnt++;
      end
      chk("t5_no_late_valid", 128'(valid_cnt), 128'(0));
      chk("t5_idle_after_rst", 128'(busy_cnt), 128'(0));
      chk("t5_data_still_zero", 128'(data1), 128'(0));
      addr1 = seq_addr(12'h050);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      n = 1;
      while (!valid1 && n < 40) begin
         tick();
         n++;
      end
      chk("t5_new_latency", 128'(n), 128'(12));
      chk("t5_new_data", 128'(data1), 128'(72'h585756555453525150));

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_src_ram_read_seq

// File: doc/src_ram_read_seq.md
# src_ram_read_seq

Read responder on the source feature-map RAM. It takes the packed 9-lane address bundle and start pulse from the convolution/average-pool address mux. It serialises the lanes onto one single-port synchronous RAM read port and returns the 9 read bytes as one packed word with a one-cycle valid pulse. It sits between the address-source mux and the source RAM, and feeds the compute datapath (conv or pool, whichever issued the addresses).

## Interface
Parameters:
- LANES, 9, number of addresses per request (3x3 window)
- ADDR_W, 12, width of one lane address
- DATA_W, 8, width of one RAM word
- RAM_LAT, 1, RAM read latency in cycles, from the read-enable cycle to the data cycle (legal range 1..3)

Ports:
- i_clk  in  1  clock; all logic rises on posedge
- i_rstn  in  1  reset, asynchronous assert, active-low
- i_addr  in  LANES*ADDR_W  packed addresses; lane j = bits [j*ADDR_W +: ADDR_W]
- i_startRead  in  1  request strobe, sampled on posedge
- o_ramAddr  out  ADDR_W  RAM read address
- o_ramRe  out  1  RAM read enable
- i_ramData  in  DATA_W  RAM read data, valid RAM_LAT cycles after o_ramRe
- o_data  out  LANES*DATA_W  packed result; lane j = bits [j*DATA_W +: DATA_W]
- o_dataValid  out  1  one-cycle pulse when o_data is updated
- o_busy  out  1  request in progress; new starts are not accepted
- o_dropped  out  1  one-cycle pulse when a start arrives while busy

## Operation
- FSM states:
  - IDLE: on i_startRead=1, latch all of i_addr into an internal register, clear the issue counter, go to ISSUE.
  - ISSUE: drive lane k of the latched address on o_ramAddr with o_ramRe=1, for k = 0..LANES-1, one lane per cycle. After lane LANES-1, go to DRAIN.
  - DRAIN: o_ramRe=0. Wait for the last captured lane, then go to DONE.
  - DONE: single cycle. Copy the capture register to o_data, pulse o_dataValid, go to IDLE.
- Capture: a RAM_LAT-deep delay line carries {valid, lane index} for each issued read. When its output is valid, i_ramData is written into capture-register slot [index].
- o_data changes only in DONE. It holds its value until the next DONE, so partial captures are never visible.
- o_busy = 1 in ISSUE and DRAIN, and also in IDLE during the cycle a start is being accepted. o_busy = 0 in DONE and otherwise in IDLE.
- A start sampled in the DONE cycle is accepted exactly as in IDLE (back-to-back requests).
- A start sampled in ISSUE or DRAIN is ignored: o_dropped pulses the next cycle, the latched addresses are unchanged, and the current request completes normally.
- i_addr is sampled only at accept. Later changes have no effect.
- Issue counter: $clog2(LANES) bits, no wrap. It stops at LANES-1.
- Reset (any time, including mid-request) does the following:
  - state=IDLE, all counters and delay-line valids 0.
  - o_ramRe=0, o_ramAddr=0, o_data=0, o_dataValid=0, o_busy=0, o_dropped=0.
  - In-flight RAM data returning after reset release is discarded.

## Timing
- Edge E0 samples i_startRead=1. Lane j is issued in the cycle after edge E(j) (o_ramRe/o_ramAddr registered).
- Lane j is captured at edge E(1+j+RAM_LAT).
- o_dataValid is high for the single cycle after edge E(LANES+RAM_LAT+1).
- Latency from start edge to the valid cycle is LANES+RAM_LAT+2 cycles: 12 with the defaults.
- Minimum start-to-start spacing is LANES+RAM_LAT+2 cycles (a start accepted in DONE achieves it).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package src_ram_pkg holds:
  - the LANES, ADDR_W and DATA_W defaults,
  - the FSM state enum (IDLE, ISSUE, DRAIN, DONE),
  - a lane-index width constant.
- The mux driving this block and the compute blocks import the same package.
- One sub-module, ram_lat_pipe: a parameterised RAM_LAT-stage shift register of {valid, index}, reset to all-invalid. It is reused later for write-back latency matching.

## Test plan
- Single request, defaults. RAM model holds mem[a] = a[7:0]; addresses 0x010..0x018 in lanes 0..8 → o_ramAddr shows 0x010..0x018 on 9 consecutive cycles; o_dataValid pulses 12 cycles after start; o_data = 0x181716151413121110.
- Request with RAM_LAT=3 and addresses all 0xFFF (mem=0xA5) → o_data = 9 bytes of 0xA5; valid pulses 14 cycles after start; o_busy is high for exactly 13 cycles.
- Start pulse held high for 3 cycles → one request accepted; o_dropped pulses twice; only one o_dataValid.
- Back-to-back: second start sampled in the DONE cycle with new addresses 0x100..0x108 → second o_dataValid pulses exactly 12 cycles after the first; first o_data is held stable until then.
- Reset asserted on the 5th ISSUE cycle → all outputs 0 immediately. After release, the late RAM data for the aborted read produces no capture. A new request then returns correct data.
- i_addr changed every cycle after accept → result reflects only the addresses sampled at accept.
